acc_mem_arbiter: RTL and testbench

//  Shares the accumulator CPU's single-port 1K x 16 synchronous memory between two

---
 rtl/acc_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_acc_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - two-port req/ack arbiter for the accumulator CPU's 1K x 16 RAM with one memory-mapped IO word
module acc_mem_arbiter #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] IO_ADDR    = 16'hFFFE,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [15:0]           c_addr,
  input  logic [15:0]           c_wdata,
  output logic                  c_ack,
  output logic [15:0]           c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [15:0]           d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_ack,
  output logic [15:0]           d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_we,
  input  logic [15:0]           mem_q,
  input  logic [15:0]           IOIn,
  output logic [15:0]           IOOut,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, last_grant_q;
  logic                    we_q, io_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [15:0]             mem_data_q;
  logic [15:0]             c_rdata_q, d_rdata_q, io_out_q;

  // Combinational decode shared by the register blocks
  logic                    grant_en;
  logic                    grant_d;
  logic                    sel_we;
  logic                    sel_io;
  logic [15:0]             sel_addr;
  logic [15:0]             sel_wdata;
  logic                    rd_load;
  logic [15:0]             rd_val;
  logic                    io_wr;

  // State register; an async reset abandons any access in flight
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: RAM reads take an extra cycle to capture mem_q
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (c_req || d_req) state_d = S_ISSUE;
      S_ISSUE: state_d = (!we_q && !io_q) ? S_READ : S_DONE;
      S_READ:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and arbitration decode derived from the current state
  always_comb begin
    grant_en  = (state_q == S_IDLE) && (c_req || d_req);
    if (c_req && d_req) grant_d = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    else                grant_d = d_req;
    sel_we    = grant_d ? d_we    : c_we;
    sel_addr  = grant_d ? d_addr  : c_addr;
    sel_wdata = grant_d ? d_wdata : c_wdata;
    // IO decode uses the full address so aliases of the IO word still reach RAM
    sel_io    = (sel_addr == IO_ADDR);
    busy      = (state_q != S_IDLE);
    c_ack     = (state_q == S_DONE) && !owner_q;
    d_ack     = (state_q == S_DONE) &&  owner_q;
    rd_load   = 1'b0;
    rd_val    = mem_q;
    io_wr     = 1'b0;
    if (state_q == S_ISSUE && io_q) begin
      if (we_q) begin
        io_wr = 1'b1;
      end else begin
        rd_load = 1'b1;
        rd_val  = IOIn;
      end
    end else if (state_q == S_READ) begin
      rd_load = 1'b1;
    end
  end

  // Grant capture: latch the winner's request and present it to the RAM in ISSUE
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      io_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (grant_en) begin
        owner_q      <= grant_d;
        last_grant_q <= grant_d;
        we_q         <= sel_we;
        io_q         <= sel_io;
        mem_addr_q   <= sel_addr[ADDR_WIDTH-1:0];
        mem_data_q   <= sel_wdata;
        mem_we_q     <= sel_we && !sel_io;
      end
    end
  end

  // Read data and IO output registers; only the owner's rdata ever changes
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      io_out_q  <= '0;
    end else begin
      if (rd_load) begin
        if (owner_q) d_rdata_q <= rd_val;
        else         c_rdata_q <= rd_val;
      end
      if (io_wr) io_out_q <= mem_data_q;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign IOOut    = io_out_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb/tb_acc_mem_arbiter.sv - directed self-checking bench for acc_mem_arbiter
module tb_acc_mem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [15:0] c_addr = '0, c_wdata = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [15:0] d_addr = '0, d_wdata = '0;
  logic        c_ack, d_ack;
  logic [15:0] c_rdata, d_rdata;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [15:0] mem_q = '0;
  logic [15:0] IOIn = '0;
  logic [15:0] IOOut;
  logic        busy, owner;

  logic        c_req_fp = 1'b0, d_req_fp = 1'b0;
  logic        c_ack_fp, d_ack_fp;
  logic [15:0] c_rdata_fp, d_rdata_fp;
  logic [9:0]  mem_addr_fp;
  logic [15:0] mem_data_fp;
  logic        mem_we_fp;
  logic [15:0] mem_q_fp = '0;
  logic [15:0] IOOut_fp;
  logic        busy_fp, owner_fp;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram [0:1023];
  int          we_cnt = 0;
  logic [9:0]  last_we_addr = '0;
  logic [15:0] last_we_data = '0;

  always #5 CLK = ~CLK;

  acc_mem_arbiter #(.ADDR_WIDTH(10), .IO_ADDR(16'hFFFE), .FIXED_PRIO(1'b0)) dut (
    .CLK(CLK), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .IOIn(IOIn), .IOOut(IOOut), .busy(busy), .owner(owner)
  );

  acc_mem_arbiter #(.ADDR_WIDTH(10), .IO_ADDR(16'hFFFE), .FIXED_PRIO(1'b1)) dut_fp (
    .CLK(CLK), .Reset(Reset),
    .c_req(c_req_fp), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack_fp), .c_rdata(c_rdata_fp),
    .d_req(d_req_fp), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack_fp), .d_rdata(d_rdata_fp),
    .mem_addr(mem_addr_fp), .mem_data(mem_data_fp), .mem_we(mem_we_fp), .mem_q(mem_q_fp),
    .IOIn(IOIn), .IOOut(IOOut_fp), .busy(busy_fp), .owner(owner_fp)
  );

  // Synchronous single-port RAM: one-cycle read latency
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  // Count write-enable cycles away from the clock edge
  always @(negedge CLK) begin
    if (mem_we) begin
      we_cnt++;
      last_we_addr = mem_addr;
      last_we_data = mem_data;
    end
  end

  task automatic access(input bit port, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output logic [15:0] rd);
    @(posedge CLK); #1;
    if (!port) begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if ((!port && c_ack) || (port && d_ack)) begin
        lat = k;
        rd  = port ? d_rdata : c_rdata;
        break;
      end
    end
    @(posedge CLK); #1;
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (c_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b%b exp=00", c_ack, d_ack); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
    checks++; if (IOOut !== 16'h0000) begin errors++; $display("FAIL reset_ioout got=%h exp=0000", IOOut); end
    checks++; if (c_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0000/0000", c_rdata, d_rdata); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got=%b exp=0", owner); end
    #1 Reset = 1'b1;
  endtask

  task automatic test_ram_write();
    int lat; logic [15:0] rd; int w0;
    w0 = we_cnt;
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL wr_we_pulses got=%0d exp=1", we_cnt - w0); end
    checks++; if (last_we_addr !== 10'h010) begin errors++; $display("FAIL wr_addr got=%h exp=010", last_we_addr); end
    checks++; if (last_we_data !== 16'hBEEF) begin errors++; $display("FAIL wr_data got=%h exp=beef", last_we_data); end
  endtask

  task automatic test_ram_read();
    int lat; logic [15:0] rd; logic [15:0] d_before;
    d_before = d_rdata;
    access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%h exp=beef", rd); end
    checks++; if (d_rdata !== d_before) begin errors++; $display("FAIL rd_d_untouched got=%h exp=%h", d_rdata, d_before); end
    @(negedge CLK);
    checks++; if (c_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data_hold got=%h exp=beef", c_rdata); end
  endtask

  task automatic test_io();
    int lat; logic [15:0] rd; int w0;
    w0 = we_cnt;
    access(1'b1, 1'b1, 16'hFFFE, 16'h1234, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL io_wr_latency got=%0d exp=2", lat); end
    checks++; if (IOOut !== 16'h1234) begin errors++; $display("FAIL io_wr_ioout got=%h exp=1234", IOOut); end
    checks++; if (we_cnt !== w0) begin errors++; $display("FAIL io_wr_no_mem_we got=%0d exp=%0d", we_cnt, w0); end
    IOIn = 16'h00AA;
    access(1'b1, 1'b0, 16'hFFFE, 16'h0000, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL io_rd_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 16'h00AA) begin errors++; $display("FAIL io_rd_data got=%h exp=00aa", rd); end
    checks++; if (c_rdata !== 16'hBEEF) begin errors++; $display("FAIL io_rd_c_untouched got=%h exp=beef", c_rdata); end
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL io_owner_hold got=%b exp=1", owner); end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] rd;
    access(1'b0, 1'b1, 16'h0405, 16'h5555, lat, rd);
    checks++; if (last_we_addr !== 10'h005) begin errors++; $display("FAIL wrap_addr got=%h exp=005", last_we_addr); end
    access(1'b0, 1'b0, 16'h0005, 16'h0000, lat, rd);
    checks++; if (rd !== 16'h5555) begin errors++; $display("FAIL wrap_rd got=%h exp=5555", rd); end
  endtask

  task automatic test_round_robin();
    bit exp_seq [4];
    bit got [4];
    int n;
    // previous access was by C, so the first tie goes to D
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
    @(posedge CLK); #1;
    c_we = 1'b1; c_addr = 16'h0020; c_wdata = 16'h0C0C;
    d_we = 1'b1; d_addr = 16'h0021; d_wdata = 16'h0D0D;
    c_req = 1'b1; d_req = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge CLK);
      if (c_ack) begin got[n] = 1'b0; n++; end
      else if (d_ack) begin got[n] = 1'b1; n++; end
    end
    c_req = 1'b0; d_req = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, got[i], exp_seq[i]); end
    end
    repeat (6) @(posedge CLK);
  endtask

  task automatic test_fixed_prio();
    int nc, nd;
    @(posedge CLK); #1;
    c_we = 1'b1; c_addr = 16'h0030; d_we = 1'b1; d_addr = 16'h0031;
    c_req_fp = 1'b1; d_req_fp = 1'b1;
    nc = 0; nd = 0;
    for (int k = 0; k < 40 && (nc + nd) < 3; k++) begin
      @(negedge CLK);
      if (c_ack_fp) nc++;
      if (d_ack_fp) nd++;
    end
    checks++; if (nc !== 3 || nd !== 0) begin errors++; $display("FAIL fp_c_wins got=c%0d/d%0d exp=c3/d0", nc, nd); end
    c_req_fp = 1'b0;
    for (int k = 0; k < 20 && nd == 0; k++) begin
      @(negedge CLK);
      if (c_ack_fp) nc++;
      if (d_ack_fp) nd++;
    end
    checks++; if (nd !== 1 || nc !== 3) begin errors++; $display("FAIL fp_d_after_c got=c%0d/d%0d exp=c3/d1", nc, nd); end
    d_req_fp = 1'b0;
    repeat (6) @(posedge CLK);
  endtask

  task automatic test_reset_mid();
    bit ack_seen;
    bit first;
    bit got_any;
    @(posedge CLK); #1;
    c_we = 1'b1; c_addr = 16'h0040; c_wdata = 16'hDEAD; c_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_mid_issue_we got=%b exp=1", mem_we); end
    #1 Reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we_drop got=%b exp=0", mem_we); end
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (c_ack || d_ack) ack_seen = 1'b1;
    end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ack got=%b exp=0", ack_seen); end
    c_req = 1'b0;
    @(posedge CLK); #1 Reset = 1'b1;
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(posedge CLK); #1;
    c_we = 1'b1; c_addr = 16'h0050; d_we = 1'b1; d_addr = 16'h0051;
    c_req = 1'b1; d_req = 1'b1;
    got_any = 1'b0; first = 1'b1;
    for (int k = 0; k < 20 && !got_any; k++) begin
      @(negedge CLK);
      if (c_ack) begin got_any = 1'b1; first = 1'b0; end
      else if (d_ack) begin got_any = 1'b1; first = 1'b1; end
    end
    c_req = 1'b0; d_req = 1'b0;
    checks++; if (got_any !== 1'b1 || first !== 1'b0) begin errors++; $display("FAIL rst_mid_tie_to_c got=seen%b/port%b exp=seen1/port0", got_any, first); end
    repeat (6) @(posedge CLK);
  endtask

  initial begin
    test_reset();
    test_ram_write();
    test_ram_read();
    test_io();
    test_wrap();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
